instr_fetch: RTL and testbench

//   Instruction fetch stage and IF/ID pipeline register feeding the instruction decoder/controller.

---
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage and IF/ID register. A skid buffer holds a word returned
// during a decode stall, and a jr redirect drains any stale in-flight response.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] if_id_ins,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] skid;
    logic        jr_take;

    // A redirect only counts when decode is actually holding a real instruction.
    assign jr_take  = jr && if_id_valid;
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (jr_take) begin
            // The memory still owes a word for the old pc; swallow it before refetching.
            if (state == S_FETCH && !imem_ready) begin
                next_state = S_DRAIN;
            end else begin
                next_state = S_FETCH;
            end
        end else begin
            case (state)
                S_FETCH: if (imem_ready && stall) next_state = S_HOLD;
                S_HOLD:  if (!stall)              next_state = S_FETCH;
                S_DRAIN: if (imem_ready)          next_state = S_FETCH;
                default:                          next_state = S_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req  = rst_n && (state == S_FETCH);
        imem_addr = pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            skid        <= NOP_INS;
            if_id_ins   <= NOP_INS;
            if_id_pc4   <= 32'd0;
            if_id_valid <= 1'b0;
        end else if (jr_take) begin
            pc          <= jr_target & ~32'h3;
            skid        <= NOP_INS;
            if_id_ins   <= NOP_INS;
            if_id_valid <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready && !stall) begin
                        if_id_ins   <= imem_rdata;
                        if_id_pc4   <= pc_plus4;
                        if_id_valid <= 1'b1;
                        pc          <= pc_plus4;
                    end else if (imem_ready) begin
                        skid <= imem_rdata;
                    end else if (!stall) begin
                        if_id_ins   <= NOP_INS;
                        if_id_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_id_ins   <= skid;
                        if_id_pc4   <= pc_plus4;
                        if_id_valid <= 1'b1;
                        pc          <= pc_plus4;
                    end
                end
                S_DRAIN: begin
                    if_id_ins   <= NOP_INS;
                    if_id_valid <= 1'b0;
                end
                default: begin
                    if_id_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: variable-latency memory model returning addr>>2,
// scoreboard of expected IF/ID contents, and a second instance for pc wraparound.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ready = 1'b0;
    logic [31:0] if_id_ins;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    logic        rst2_n = 1'b0;
    logic        ready2 = 1'b1;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic [31:0] if_id_ins2;
    logic [31:0] if_id_pc4_2;
    logic        if_id_valid2;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 1;
    bit          mem_on = 1'b0;
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;
    logic        last_stall = 1'b0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .NOP_INS (NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .jr         (jr),
        .jr_target  (jr_target),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .if_id_ins  (if_id_ins),
        .if_id_pc4  (if_id_pc4),
        .if_id_valid(if_id_valid)
    );

    instr_fetch #(
        .RESET_PC(32'hFFFF_FFF8),
        .NOP_INS (NOP)
    ) dut_wrap (
        .clk        (clk),
        .rst_n      (rst2_n),
        .stall      (1'b0),
        .jr         (1'b0),
        .jr_target  (32'd0),
        .imem_req   (imem_req2),
        .imem_addr  (imem_addr2),
        .imem_rdata (imem_rdata2),
        .imem_ready (ready2),
        .if_id_ins  (if_id_ins2),
        .if_id_pc4  (if_id_pc4_2),
        .if_id_valid(if_id_valid2)
    );

    assign imem_rdata2 = imem_addr2 >> 2;

    always #5 clk = ~clk;

    always @(posedge clk) last_stall <= stall;

    // Memory answers mem_lat cycles after accepting a request and keeps an accepted
    // request alive even if the fetcher drops imem_req.
    always @(negedge clk) begin
        #1;
        imem_ready = 1'b0;
        if (!rst_n || !mem_on) begin
            mem_busy = 1'b0;
            mem_cnt  = 0;
        end else begin
            if (!mem_busy && imem_req) begin
                mem_busy = 1'b1;
                mem_cnt  = 0;
                mem_addr = imem_addr;
            end
            if (mem_busy) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    imem_ready = 1'b1;
                    imem_rdata = mem_addr >> 2;
                    mem_busy   = 1'b0;
                end
            end
        end
    end

    // A valid IF/ID after an unstalled edge is a freshly loaded instruction.
    always @(negedge clk) begin
        if (rst_n && if_id_valid && !last_stall) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_unexpected: got ins=%h pc4=%h, expected no instruction", if_id_ins, if_id_pc4);
            end else begin
                mon_e = exp_q.pop_front();
                if (if_id_ins !== mon_e.ins || if_id_pc4 !== mon_e.pc4) begin
                    errors++;
                    $display("[TB] FAIL scoreboard_ins: got ins=%h pc4=%h, expected ins=%h pc4=%h",
                             if_id_ins, if_id_pc4, mon_e.ins, mon_e.pc4);
                end
            end
        end
    end

    task automatic do_reset(input int lat);
        @(negedge clk);
        rst_n  = 1'b0;
        mem_on = 1'b0;
        stall  = 1'b0;
        jr     = 1'b0;
        repeat (2) @(negedge clk);
        mem_lat = lat;
        mem_on  = 1'b1;
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        mem_on = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b, expected 0", imem_req); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, expected 0", if_id_valid); end
        checks++; if (if_id_ins !== NOP) begin errors++; $display("[TB] FAIL reset_ins: got %h, expected %h", if_id_ins, NOP); end
        checks++; if (if_id_pc4 !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc4: got %h, expected 0", if_id_pc4); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL release_req: got %b, expected 1", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL release_addr: got %h, expected 0", imem_addr); end
    endtask

    task automatic test_continuous();
        for (int i = 0; i < 4; i++) exp_q.push_back('{32'(i), 32'(4 * i + 4)});
        do_reset(1);
        #1;
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL cont_first_valid: got %b, expected 0", if_id_valid); end
        repeat (4) @(negedge clk);
        mem_on = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL cont_pending: got %0d left, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_latency();
        for (int i = 0; i < 3; i++) exp_q.push_back('{32'(i), 32'(4 * i + 4)});
        do_reset(3);
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                #1;
                checks++; if (if_id_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_bubble_valid: got %b, expected 0", if_id_valid); end
                checks++; if (if_id_ins !== NOP) begin errors++; $display("[TB] FAIL lat_bubble_ins: got %h, expected %h", if_id_ins, NOP); end
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
                    errors++; $display("[TB] FAIL lat_addr: got req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, 32'(4 * i));
                end
            end
            @(negedge clk);
        end
        mem_on = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL lat_pending: got %0d left, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) exp_q.push_back('{32'(i), 32'(4 * i + 4)});
        do_reset(1);
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b, expected 0", imem_req); end
            checks++; if (if_id_valid !== 1'b1 || if_id_ins !== 32'd0 || if_id_pc4 !== 32'd4) begin
                errors++; $display("[TB] FAIL stall_frozen: got v=%b ins=%h pc4=%h, expected v=1 ins=0 pc4=4", if_id_valid, if_id_ins, if_id_pc4);
            end
        end
        stall = 1'b0;
        repeat (3) @(negedge clk);
        mem_on = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL stall_pending: got %0d left, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_jr();
        exp_q.push_back('{32'h0, 32'h4});
        exp_q.push_back('{32'h40, 32'h104});
        exp_q.push_back('{32'h41, 32'h108});
        do_reset(1);
        @(negedge clk);
        jr        = 1'b1;
        jr_target = 32'h0000_0103;
        @(negedge clk);
        jr = 1'b0;
        #1;
        checks++; if (if_id_valid !== 1'b0 || if_id_ins !== NOP) begin
            errors++; $display("[TB] FAIL jr_flush: got v=%b ins=%h, expected v=0 ins=%h", if_id_valid, if_id_ins, NOP);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL jr_addr: got req=%b addr=%h, expected req=1 addr=100", imem_req, imem_addr);
        end
        repeat (2) @(negedge clk);
        mem_on = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL jr_pending: got %0d left, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_jr_drain();
        exp_q.push_back('{32'h0, 32'h4});
        exp_q.push_back('{32'h40, 32'h104});
        do_reset(3);
        @(negedge clk);
        jr        = 1'b1;
        jr_target = 32'h0000_0200;
        @(negedge clk);
        jr = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL jr_ignored: got addr=%h, expected 0", imem_addr); end
        @(negedge clk);
        jr        = 1'b1;
        jr_target = 32'h0000_0103;
        @(negedge clk);
        jr = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL drain_state: got req=%b v=%b, expected req=0 v=0", imem_req, if_id_valid);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL drain_refetch: got req=%b addr=%h, expected req=1 addr=100", imem_req, imem_addr);
        end
        repeat (3) @(negedge clk);
        mem_on = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL drain_pending: got %0d left, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_hold();
        exp_q.push_back('{32'h0, 32'h4});
        do_reset(1);
        @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL hold_req: got %b, expected 0", imem_req); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (if_id_valid !== 1'b0 || if_id_ins !== NOP || if_id_pc4 !== 32'd0 || imem_req !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset: got v=%b ins=%h pc4=%h req=%b, expected v=0 ins=%h pc4=0 req=0",
                               if_id_valid, if_id_ins, if_id_pc4, imem_req, NOP);
        end
        @(negedge clk);
        stall = 1'b0;
        exp_q.push_back('{32'h0, 32'h4});
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL restart_addr: got req=%b addr=%h, expected req=1 addr=0", imem_req, imem_addr);
        end
        @(negedge clk);
        mem_on = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL hold_pending: got %0d left, expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_wrap();
        logic [31:0] addr_q[$];
        logic [31:0] exp_addr;
        logic [31:0] prev_addr;
        addr_q    = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        prev_addr = 32'd0;
        @(negedge clk);
        rst2_n = 1'b0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_addr = addr_q.pop_front();
            checks++; if (imem_addr2 !== exp_addr) begin
                errors++; $display("[TB] FAIL wrap_addr: got %h, expected %h", imem_addr2, exp_addr);
            end
            if (i > 0) begin
                checks++; if (if_id_valid2 !== 1'b1 || if_id_ins2 !== (prev_addr >> 2) || if_id_pc4_2 !== prev_addr + 32'd4) begin
                    errors++; $display("[TB] FAIL wrap_ifid: got v=%b ins=%h pc4=%h, expected v=1 ins=%h pc4=%h",
                                       if_id_valid2, if_id_ins2, if_id_pc4_2, prev_addr >> 2, prev_addr + 32'd4);
                end
            end
            prev_addr = exp_addr;
            @(negedge clk);
        end
        rst2_n = 1'b0;
    endtask

    initial begin
        $display("[TB] starting instr_fetch bench");
        test_reset();
        test_continuous();
        test_latency();
        test_stall();
        test_jr();
        test_jr_drain();
        test_reset_hold();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
